// File: rtl/subtractor_4bits_serial.sv
// Bit-serial unsigned subtractor (a - b), LSB first, with a start/busy/done handshake.
// Define SUBTRACTOR_SATURATE_EN to clamp diff at zero when the result borrows.
module subtractor_4bits_serial #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] diff,
   output logic             bo,
   output logic             busy,
   output logic             done
);

   localparam int CW = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
`ifdef SUBTRACTOR_SATURATE_EN
   localparam bit SAT_EN = 1'b1;
`else
   localparam bit SAT_EN = 1'b0;
`endif

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] ra_q, ra_d, rb_q, rb_d, sh_q, sh_d;
   logic [WIDTH-1:0] diff_q, diff_d;
   logic             br_q, br_d, bo_q, bo_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             bit_d, br_nxt;

   function automatic logic [WIDTH-1:0] sat_result(input logic [WIDTH-1:0] raw,
                                                   input logic borrow);
      return (SAT_EN && borrow) ? '0 : raw;
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         ra_q    <= '0;
         rb_q    <= '0;
         sh_q    <= '0;
         br_q    <= 1'b0;
         cnt_q   <= '0;
         diff_q  <= '0;
         bo_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         ra_q    <= ra_d;
         rb_q    <= rb_d;
         sh_q    <= sh_d;
         br_q    <= br_d;
         cnt_q   <= cnt_d;
         diff_q  <= diff_d;
         bo_q    <= bo_d;
      end
   end

   always_comb begin
      state_d = state_q;
      ra_d    = ra_q;
      rb_d    = rb_q;
      sh_d    = sh_q;
      br_d    = br_q;
      cnt_d   = cnt_q;
      diff_d  = diff_q;
      bo_d    = bo_q;
      bit_d   = ra_q[0] ^ rb_q[0] ^ br_q;
      br_nxt  = (~ra_q[0] & rb_q[0]) | (~(ra_q[0] ^ rb_q[0]) & br_q);
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               ra_d    = a;
               rb_d    = b;
               br_d    = 1'b0;
               cnt_d   = '0;
               state_d = S_CALC;
            end
         end
         S_CALC: begin
            ra_d  = ra_q >> 1;
            rb_d  = rb_q >> 1;
            sh_d  = {bit_d, sh_q[WIDTH-1:1]};
            br_d  = br_nxt;
            cnt_d = cnt_q + CW'(1);
            // Last bit: publish the assembled word, including the bit just produced.
            if (cnt_q == LAST) begin
               diff_d  = sat_result({bit_d, sh_q[WIDTH-1:1]}, br_nxt);
               bo_d    = br_nxt;
               state_d = S_DONE;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   assign diff = diff_q;
   assign bo   = bo_q;
   assign busy = (state_q == S_CALC);
   assign done = (state_q == S_DONE);

endmodule
